// File: rtl/vehicle_req_cond_if.sv
// Handshake bundle between the farm-road sensor conditioner and the light
// controller.
//   sensor_raw : raw loop sensor (async, bouncy)     -> conditioner
//   grant      : farm green is showing               -> conditioner
//   req        : vehicle request (C input)           <- conditioner
//   car_count  : queued cars, saturating at 15       <- conditioner
//   sensor_db  : debounced sensor level              <- conditioner
//   state      : IDLE=00 WAITING=01 REQUEST=10 SERVING=11
interface vehicle_req_cond_if;
  logic       sensor_raw;
  logic       grant;
  logic       req;
  logic [3:0] car_count;
  logic       sensor_db;
  logic [1:0] state;

  modport master (output sensor_raw, grant,
                  input  req, car_count, sensor_db, state);
  modport slave  (input  sensor_raw, grant,
                  output req, car_count, sensor_db, state);
endinterface

// File: rtl/vehicle_req_cond.sv
// Farm-road vehicle request conditioner: synchronizes and debounces the loop
// sensor, counts queued cars, and raises a registered request level toward
// the light controller when enough cars queue or one has waited too long.
//   clk : single clock, rising edge
//   rst : synchronous, active-high
//   bus : vehicle_req_cond_if.slave (sensor_raw, grant in; req, car_count,
//         sensor_db, state out)
module vehicle_req_cond #(
  parameter int DEBOUNCE     = 4,
  parameter int THRESH       = 3,
  parameter int MAX_WAIT     = 20,
  parameter int SERVE_CYCLES = 2
) (
  input  logic             clk,
  input  logic             rst,
  vehicle_req_cond_if.slave bus
);
  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    WAITING = 2'b01,
    REQUEST = 2'b10,
    SERVING = 2'b11
  } state_t;

  localparam logic [3:0] DB_LAST  = 4'(DEBOUNCE - 1);
  localparam logic [3:0] SRV_LAST = 4'(SERVE_CYCLES - 1);
  localparam logic [7:0] WAIT_MAX = 8'(MAX_WAIT);
  localparam logic [4:0] THR      = 5'(THRESH);

  state_t     st;
  logic       sync1, sync2, db, db_q, req_r;
  logic [3:0] stab_cnt, cnt, srv_cnt;
  logic [7:0] wait_t;

  logic arrival, serve_done, dec;
  assign arrival    = db & ~db_q;
  assign serve_done = (st == SERVING) && bus.grant && (srv_cnt == SRV_LAST);
  // A serve slot with an empty queue simply expires; the count never underflows.
  assign dec        = serve_done && (cnt != 4'd0);

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1    <= 1'b0;
      sync2    <= 1'b0;
      stab_cnt <= 4'd0;
      db       <= 1'b0;
      db_q     <= 1'b0;
      cnt      <= 4'd0;
      wait_t   <= 8'd0;
      srv_cnt  <= 4'd0;
      req_r    <= 1'b0;
      st       <= IDLE;
    end else begin
      // sensor path runs in every state
      sync1 <= bus.sensor_raw;
      sync2 <= sync1;
      db_q  <= db;
      if (sync2 == db) begin
        stab_cnt <= 4'd0;
      end else if (stab_cnt == DB_LAST) begin
        db       <= sync2;
        stab_cnt <= 4'd0;
      end else begin
        stab_cnt <= stab_cnt + 4'd1;
      end

      // arrival and departure on the same edge cancel out
      case ({arrival, dec})
        2'b10:   if (cnt != 4'd15) cnt <= cnt + 4'd1;
        2'b01:   cnt <= cnt - 4'd1;
        default: ;
      endcase

      // Held at zero outside WAITING, so every entry starts from zero.
      if (st != WAITING)        wait_t <= 8'd0;
      else if (wait_t != WAIT_MAX) wait_t <= wait_t + 8'd1;

      // Leaving SERVING only happens on grant=0, which clears this too.
      if (st == SERVING && bus.grant) srv_cnt <= serve_done ? 4'd0 : srv_cnt + 4'd1;
      else                            srv_cnt <= 4'd0;

      // req mirrors the next state, so it is a pure flop output
      req_r <= 1'b0;
      case (st)
        IDLE: begin
          if (bus.grant)        st <= SERVING;
          else if (cnt != 4'd0) st <= WAITING;
        end
        WAITING: begin
          if (bus.grant) begin
            st <= SERVING;
          end else if ({1'b0, cnt} >= THR || wait_t == WAIT_MAX) begin
            st    <= REQUEST;
            req_r <= 1'b1;
          end
        end
        REQUEST: begin
          if (bus.grant) st    <= SERVING;
          else           req_r <= 1'b1;
        end
        SERVING: begin
          if (!bus.grant) st <= (cnt != 4'd0) ? WAITING : IDLE;
        end
        default: st <= IDLE;
      endcase
    end
  end

  assign bus.req       = req_r;
  assign bus.car_count = cnt;
  assign bus.sensor_db = db;
  assign bus.state     = st;
endmodule

// File: tb/tb_vehicle_req_cond.sv
// Directed bench for vehicle_req_cond. MAX_WAIT is raised to 40 so that three
// debounced arrivals (12 cycles apart at best) reach the threshold before the
// wait timeout; the timeout check is written in terms of MW.
module tb_vehicle_req_cond;
  localparam int MW = 40;

  logic clk = 1'b0;
  logic rst;
  int   vecs = 0;
  int   errs = 0;

  vehicle_req_cond_if bus();

  vehicle_req_cond #(
    .DEBOUNCE(4), .THRESH(3), .MAX_WAIT(MW), .SERVE_CYCLES(2)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    vecs++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.sensor_raw = 1'b0;
    bus.grant = 1'b0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  // raw high 6 edges then one low edge: count has just incremented on return
  task automatic arrive();
    bus.sensor_raw = 1'b1;
    repeat (6) tick();
    bus.sensor_raw = 1'b0;
    tick();
  endtask

  // remaining low edges so sensor_db falls before the next arrival
  task automatic gap();
    repeat (5) tick();
  endtask

  initial begin
    // reset state
    do_reset();
    chk("rst_req",   8'(bus.req), 8'd0);
    chk("rst_cnt",   8'(bus.car_count), 8'd0);
    chk("rst_db",    8'(bus.sensor_db), 8'd0);
    chk("rst_state", 8'(bus.state), 8'd0);

    // IDLE goes straight to SERVING on grant, and back when it drops
    bus.grant = 1'b1; tick();
    chk("idle_grant_state", 8'(bus.state), 8'd3);
    bus.grant = 1'b0; tick();
    chk("serve_empty_state", 8'(bus.state), 8'd0);

    // held sensor: debounce latency, arrival, WAITING, then wait timeout
    do_reset();
    bus.sensor_raw = 1'b1;
    for (int e = 1; e <= MW + 12; e++) begin
      tick();
      if (e == 5) chk("db_e5", 8'(bus.sensor_db), 8'd0);
      if (e == 6) begin
        chk("db_e6", 8'(bus.sensor_db), 8'd1);
        chk("cnt_e6", 8'(bus.car_count), 8'd0);
      end
      if (e == 7) begin
        chk("cnt_e7", 8'(bus.car_count), 8'd1);
        chk("state_e7", 8'(bus.state), 8'd0);
      end
      if (e == 8) chk("state_e8", 8'(bus.state), 8'd1);
      if (e == MW + 8) begin
        chk("req_pre_timeout", 8'(bus.req), 8'd0);
        chk("state_pre_timeout", 8'(bus.state), 8'd1);
      end
      if (e == MW + 9) chk("state_timeout", 8'(bus.state), 8'd2);
      if (e >= MW + 9) chk("req_timeout_hold", 8'(bus.req), 8'd1);
    end

    // 3-on / 3-off bounce never passes the debouncer
    do_reset();
    for (int p = 0; p < 5; p++) begin
      bus.sensor_raw = 1'b1;
      repeat (3) begin tick(); chk("glitch_db", 8'(bus.sensor_db), 8'd0); end
      bus.sensor_raw = 1'b0;
      repeat (3) begin tick(); chk("glitch_db", 8'(bus.sensor_db), 8'd0); end
    end
    chk("glitch_cnt", 8'(bus.car_count), 8'd0);

    // three arrivals -> REQUEST on the next edge, hold, then serve out
    do_reset();
    arrive(); gap();
    arrive(); gap();
    arrive();
    chk("thr_cnt", 8'(bus.car_count), 8'd3);
    chk("thr_req_pre", 8'(bus.req), 8'd0);
    chk("thr_state_pre", 8'(bus.state), 8'd1);
    tick();
    chk("thr_req", 8'(bus.req), 8'd1);
    chk("thr_state", 8'(bus.state), 8'd2);
    repeat (4) begin tick(); chk("req_hold", 8'(bus.req), 8'd1); end
    bus.grant = 1'b1;
    tick();
    chk("grant_state", 8'(bus.state), 8'd3);
    chk("grant_req", 8'(bus.req), 8'd0);
    chk("grant_cnt", 8'(bus.car_count), 8'd3);
    // six serving edges: count 3,2,2,1,1,0
    for (int s = 1; s <= 6; s++) begin
      tick();
      chk("serve_req", 8'(bus.req), 8'd0);
      chk("serve_cnt", 8'(bus.car_count), 8'(3 - s / 2));
    end
    bus.grant = 1'b0;
    tick();
    chk("serve_done_state", 8'(bus.state), 8'd0);

    // saturation at 15, then arrival coinciding with a serve decrement
    do_reset();
    for (int k = 1; k <= 16; k++) begin
      arrive();
      chk("sat_cnt", 8'(bus.car_count), 8'((k > 15) ? 15 : k));
      gap();
    end
    chk("sat_state", 8'(bus.state), 8'd2);
    bus.sensor_raw = 1'b1;
    bus.grant = 1'b1;
    for (int e = 1; e <= 9; e++) begin
      tick();
      if (e == 1) chk("sim_e1", 8'(bus.car_count), 8'd15);
      if (e == 3) chk("sim_e3", 8'(bus.car_count), 8'd14);
      if (e == 5) chk("sim_e5", 8'(bus.car_count), 8'd13);
      if (e == 6) chk("sim_e6", 8'(bus.car_count), 8'd13);
      if (e == 7) chk("sim_e7", 8'(bus.car_count), 8'd13);
      if (e == 9) chk("sim_e9", 8'(bus.car_count), 8'd12);
    end

    // reset while requesting with five queued
    do_reset();
    for (int k = 0; k < 5; k++) begin arrive(); gap(); end
    chk("pre_rst_cnt", 8'(bus.car_count), 8'd5);
    chk("pre_rst_req", 8'(bus.req), 8'd1);
    rst = 1'b1;
    tick();
    chk("mid_rst_req", 8'(bus.req), 8'd0);
    chk("mid_rst_cnt", 8'(bus.car_count), 8'd0);
    chk("mid_rst_state", 8'(bus.state), 8'd0);
    rst = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end
endmodule
